// File: rtl/task_deserializer.sv
// Byte-stream-to-task assembler: packs 18 bytes (MSB first) into {player, opponent, taskid}
// and presents the task on a valid/ready handshake. Optional illegal-task filter: TASK_OVERLAP_CHECK_EN.
module task_deserializer #(
  parameter int TIMEOUT  = 1024,
  parameter int CNT_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [143:0]        out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_BITS-1:0] dropped,
  output logic                busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ASSEMBLE = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  // The idle counter only ever needs to reach TIMEOUT-1; the expiry fires on that cycle.
  localparam int                  IDLE_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0]   IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_BITS-1:0] DROP_MAX  = '1;
  localparam logic [4:0]          LAST_IDX  = 5'd17;

  logic [1:0]          state_q, state_d;
  logic [4:0]          index_q, index_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [143:0]        data_q, data_d;
  logic                valid_q, valid_d;
  logic [CNT_BITS-1:0] drop_q, drop_d;

  logic                accept;
  logic                expired;
  logic                illegal;
  logic [143:0]        merged;
  logic [CNT_BITS-1:0] drop_inc;

  assign in_ready  = !reset && (state_q != ST_HOLD);
  assign accept    = in_valid && in_ready;
  assign expired   = (TIMEOUT != 0) && (idle_q == IDLE_LAST);
  assign drop_inc  = (drop_q == DROP_MAX) ? drop_q : drop_q + CNT_BITS'(1);

  assign busy      = (state_q == ST_ASSEMBLE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign dropped   = drop_q;

  // Current word with the incoming byte dropped into the slot selected by index_q.
  always_comb begin
    merged = data_q;
    for (int k = 0; k < 18; k++) begin
      if (index_q == 5'(k)) begin
        merged[143 - 8*k -: 8] = in_data;
      end
    end
  end

`ifdef TASK_OVERLAP_CHECK_EN
  assign illegal = |(merged[143:80] & merged[79:16]);
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    idle_d  = idle_q;
    data_d  = data_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          data_d  = merged;
          index_d = 5'd1;
          idle_d  = '0;
          state_d = ST_ASSEMBLE;
        end
      end
      ST_ASSEMBLE: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (accept) begin
          data_d = merged;
          idle_d = '0;
          if (index_q == LAST_IDX) begin
            index_d = '0;
            if (illegal) begin
              state_d = ST_IDLE;
              drop_d  = drop_inc;
            end else begin
              state_d = ST_HOLD;
              valid_d = 1'b1;
            end
          end else begin
            index_d = index_q + 5'd1;
          end
        end else if (expired) begin
          state_d = ST_IDLE;
          index_d = '0;
          idle_d  = '0;
          drop_d  = drop_inc;
        end else if (TIMEOUT != 0) begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          index_d = '0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        index_d = '0;
        idle_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

endmodule
